// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - EX-stage op codes, bus widths and M-op decode shared by the multiply/divide unit
package ex_muldiv_pkg;

    localparam int ALU_OP_W = 8;   // AluOpBus width
    localparam int REG_W    = 32;  // RegBus width

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam logic [REG_W-1:0] ZERO_WORD = '0;

    localparam alu_op_t EX_NOP_OP    = 8'h00;
    localparam alu_op_t EX_ADD_OP    = 8'h01;
    localparam alu_op_t EX_MUL_OP    = 8'h18;
    localparam alu_op_t EX_MULH_OP   = 8'h19;
    localparam alu_op_t EX_MULHSU_OP = 8'h1A;
    localparam alu_op_t EX_MULHU_OP  = 8'h1B;
    localparam alu_op_t EX_DIV_OP    = 8'h1C;
    localparam alu_op_t EX_DIVU_OP   = 8'h1D;
    localparam alu_op_t EX_REM_OP    = 8'h1E;
    localparam alu_op_t EX_REMU_OP   = 8'h1F;

    // Per-op attributes the unit needs at start and at result selection.
    typedef struct packed {
        logic is_m;      // any RV32M op
        logic is_div;    // DIV/DIVU/REM/REMU
        logic mul_hi;    // result is the high product word
        logic want_rem;  // REM/REMU
        logic a_signed;  // rs1 treated as signed
        logic b_signed;  // rs2 treated as signed
    } mdu_dec_t;

    function automatic mdu_dec_t mdu_decode(input alu_op_t op);
        mdu_dec_t d;
        d = '0;
        case (op)
            EX_MUL_OP:    begin d.is_m = 1'b1; d.a_signed = 1'b1; d.b_signed = 1'b1; end
            EX_MULH_OP:   begin d.is_m = 1'b1; d.mul_hi = 1'b1; d.a_signed = 1'b1; d.b_signed = 1'b1; end
            EX_MULHSU_OP: begin d.is_m = 1'b1; d.mul_hi = 1'b1; d.a_signed = 1'b1; end
            EX_MULHU_OP:  begin d.is_m = 1'b1; d.mul_hi = 1'b1; end
            EX_DIV_OP:    begin d.is_m = 1'b1; d.is_div = 1'b1; d.a_signed = 1'b1; d.b_signed = 1'b1; end
            EX_DIVU_OP:   begin d.is_m = 1'b1; d.is_div = 1'b1; end
            EX_REM_OP:    begin d.is_m = 1'b1; d.is_div = 1'b1; d.want_rem = 1'b1; d.a_signed = 1'b1; d.b_signed = 1'b1; end
            EX_REMU_OP:   begin d.is_m = 1'b1; d.is_div = 1'b1; d.want_rem = 1'b1; end
            default:      d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// rtl/ex_muldiv_if.sv - ID/EX operands in, result/valid/stall out for the multiply/divide unit
// master: pipeline side (drives ex_aluop, ex_r1_data, ex_r2_data, flush)
// slave : ex_muldiv (drives mdu_result, mdu_valid, stallreq)
interface ex_muldiv_if #(
    parameter int XLEN = 32
);
    import ex_muldiv_pkg::*;

    alu_op_t          ex_aluop;
    logic [XLEN-1:0]  ex_r1_data;
    logic [XLEN-1:0]  ex_r2_data;
    logic             flush;
    logic [XLEN-1:0]  mdu_result;
    logic             mdu_valid;
    logic             stallreq;

    modport master (
        output ex_aluop, ex_r1_data, ex_r2_data, flush,
        input  mdu_result, mdu_valid, stallreq
    );

    modport slave (
        input  ex_aluop, ex_r1_data, ex_r2_data, flush,
        output mdu_result, mdu_valid, stallreq
    );
endinterface

// File: rtl/ex_muldiv_iter.sv
// rtl/ex_muldiv_iter.sv - mdu_iter_core: accumulator, step counter and one-bit-per-cycle shift-add / restoring shift-subtract
// Ports: clk, rst (sync active-high); load_i latches operand magnitudes and clears acc/counter;
// step_i advances one iteration; is_div_i picks divide vs multiply step; a_i/b_i operand magnitudes;
// acc_next_o value the accumulator takes on this step ({rem,quot} or product); last_o final iteration.
module mdu_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] acc_next_o,
    output logic              last_o
);
    localparam int CW = $clog2(XLEN) + 1;

    // a_q is consumed MSB-first: multiplier bits for Horner-style multiply, dividend bits for divide.
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;

    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     rem_n;
    logic              ge;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        // Restoring divide: high half holds the partial remainder, low half collects quotient bits.
        rem_sh   = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
        ge       = (rem_sh >= {1'b0, b_q});
        rem_n    = ge ? (rem_sh - {1'b0, b_q}) : rem_sh;
        div_next = {rem_n[XLEN-1:0], acc_q[XLEN-2:0], ge};
        mul_next = {acc_q[2*XLEN-2:0], 1'b0}
                 + (a_q[XLEN-1] ? {{XLEN{1'b0}}, b_q} : {2*XLEN{1'b0}});
        acc_next_o = is_div_i ? div_next : mul_next;
        a_d      = {a_q[XLEN-2:0], 1'b0};
    end

    assign last_o = (cnt_q == CW'(XLEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (step_i) begin
            a_q   <= a_d;
            acc_q <= acc_next_o;
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit in EX: FSM, special cases, sign handling, result register
// Ports: clk, rst (sync active-high); bus (ex_muldiv_if.slave): ex_aluop/ex_r1_data/ex_r2_data/flush in,
// mdu_result/mdu_valid/stallreq out.
// Build option: MDU_FAST_MUL_EN - multiplies use a combinational multiplier and finish in one stall cycle.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);
    import ex_muldiv_pkg::*;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q;
    logic              is_div_q, mul_hi_q, want_rem_q;
    logic              q_neg_q;   // product / quotient sign
    logic              r_neg_q;   // remainder follows the dividend
    logic [XLEN-1:0]   result_q;
    logic              valid_q;

    mdu_dec_t          dec;
    logic [XLEN-1:0]   r1, r2;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              start, div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;
    logic              short_path;
    logic [XLEN-1:0]   short_res;
    logic              core_load, core_step, core_last;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot, rem, iter_res;

    assign r1  = bus.ex_r1_data;
    assign r2  = bus.ex_r2_data;
    assign dec = mdu_decode(bus.ex_aluop);

    always_comb begin
        a_neg = dec.a_signed & r1[XLEN-1];
        b_neg = dec.b_signed & r2[XLEN-1];
        a_mag = a_neg ? ({XLEN{1'b0}} - r1) : r1;
        b_mag = b_neg ? ({XLEN{1'b0}} - r2) : r2;

        // Only IDLE may start, so the op still held in ID/EX during DONE cannot retrigger.
        start = (state_q == IDLE) & dec.is_m & ~bus.flush;

        div_zero = dec.is_div & (r2 == {XLEN{1'b0}});
        div_ovf  = dec.is_div & dec.a_signed
                 & (r1 == {1'b1, {(XLEN-1){1'b0}}}) & (r2 == {XLEN{1'b1}});
        special  = div_zero | div_ovf;
        if (div_zero)
            special_res = dec.want_rem ? r1 : {XLEN{1'b1}};
        else
            special_res = dec.want_rem ? {XLEN{1'b0}} : r1;
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_mag, fast_prod;
    always_comb begin
        fast_mag   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
        fast_prod  = (a_neg ^ b_neg) ? ({2*XLEN{1'b0}} - fast_mag) : fast_mag;
        short_path = special | ~dec.is_div;
        short_res  = dec.is_div ? special_res
                   : (dec.mul_hi ? fast_prod[2*XLEN-1:XLEN] : fast_prod[XLEN-1:0]);
    end
`else
    always_comb begin
        short_path = special;
        short_res  = special_res;
    end
`endif

    assign core_load = start & ~short_path;
    assign core_step = (state_q == BUSY) & ~bus.flush;

    mdu_iter_core #(.XLEN(XLEN)) u_core (
        .clk        (clk),
        .rst        (rst),
        .load_i     (core_load),
        .step_i     (core_step),
        .is_div_i   (is_div_q),
        .a_i        (a_mag),
        .b_i        (b_mag),
        .acc_next_o (acc_next),
        .last_o     (core_last)
    );

    // Result selection works on the value the accumulator takes on the final step.
    always_comb begin
        prod_s = q_neg_q ? ({2*XLEN{1'b0}} - acc_next) : acc_next;
        quot   = acc_next[XLEN-1:0];
        rem    = acc_next[2*XLEN-1:XLEN];
        if (is_div_q) begin
            if (want_rem_q)
                iter_res = r_neg_q ? ({XLEN{1'b0}} - rem) : rem;
            else
                iter_res = q_neg_q ? ({XLEN{1'b0}} - quot) : quot;
        end else begin
            iter_res = mul_hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            is_div_q   <= 1'b0;
            mul_hi_q   <= 1'b0;
            want_rem_q <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            result_q   <= ZERO_WORD[XLEN-1:0];
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_div_q   <= dec.is_div;
                        mul_hi_q   <= dec.mul_hi;
                        want_rem_q <= dec.want_rem;
                        q_neg_q    <= a_neg ^ b_neg;
                        r_neg_q    <= a_neg;
                        if (short_path) begin
                            result_q <= short_res;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (bus.flush) begin
                        state_q <= IDLE;
                    end else if (core_last) begin
                        result_q <= iter_res;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mdu_result = result_q;
    // A flushed instruction never writes back, even if it reached DONE.
    assign bus.mdu_valid  = valid_q & ~bus.flush;
    assign bus.stallreq   = (start | (state_q == BUSY)) & ~bus.flush;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - scoreboard bench for ex_muldiv
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] exp_q[$];

    ex_muldiv_if #(.XLEN(32)) bus ();

    ex_muldiv #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            EX_MUL_OP:    begin p = sa * sb; return p[31:0]; end
            EX_MULH_OP:   begin p = sa * sb; return p[63:32]; end
            EX_MULHSU_OP: begin p = sa * ub; return p[63:32]; end
            EX_MULHU_OP:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            EX_DIV_OP: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            EX_REM_OP: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            EX_DIVU_OP: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            EX_REMU_OP: return (b == 32'd0) ? a : a % b;
            default:    return 32'd0;
        endcase
    endfunction

    function automatic int exp_stall(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        bit is_div, sgn;
        is_div = (op == EX_DIV_OP) || (op == EX_DIVU_OP) || (op == EX_REM_OP) || (op == EX_REMU_OP);
        sgn    = (op == EX_DIV_OP) || (op == EX_REM_OP);
        if (is_div) begin
            if (b == 32'd0) return 1;
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`ifdef MDU_FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    // Drives one op in the cycle after the current edge and holds it through DONE.
    task automatic run_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b, input string tag);
        int stalls;
        int want_st;
        bit seen;
        logic [31:0] exp;
        stalls = 0;
        seen   = 1'b0;
        @(posedge clk); #1;
        bus.ex_aluop   = op;
        bus.ex_r1_data = a;
        bus.ex_r2_data = b;
        exp_q.push_back(model(op, a, b));
        want_st = exp_stall(op, a, b);
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            if (i == 0) begin
                vectors++;
                if (bus.stallreq !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s start_stall: got %b expected 1", tag, bus.stallreq);
                end
            end
            if (bus.stallreq === 1'b1) stalls++;
            if (bus.mdu_valid === 1'b1) begin
                seen = 1'b1;
                exp  = exp_q.pop_front();
                vectors++;
                if (bus.mdu_result !== exp) begin
                    miscompares++;
                    $display("FAIL %s result: got %h expected %h", tag, bus.mdu_result, exp);
                end
                vectors++;
                if (bus.stallreq !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s done_stall: got %b expected 0", tag, bus.stallreq);
                end
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: no mdu_valid within 80 cycles", tag);
            void'(exp_q.pop_front());
        end
        vectors++;
        if (stalls != want_st) begin
            miscompares++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", tag, stalls, want_st);
        end
    endtask

    // One cycle with a non-M op after DONE: no second pulse, no stall.
    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        bus.ex_aluop = EX_ADD_OP;
        @(negedge clk);
        vectors++;
        if (bus.mdu_valid !== 1'b0 || bus.stallreq !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle: got valid=%b stall=%b expected 0 0", tag, bus.mdu_valid, bus.stallreq);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ex_aluop   = EX_NOP_OP;
        bus.ex_r1_data = '0;
        bus.ex_r2_data = '0;
        bus.flush      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.mdu_result !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_result: got %h expected 00000000", bus.mdu_result);
        end
        vectors++;
        if (bus.mdu_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b expected 0", bus.mdu_valid);
        end
        vectors++;
        if (bus.stallreq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stall: got %b expected 0", bus.stallreq);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_mul();
        run_op(EX_MUL_OP, 32'd7, 32'hFFFF_FFFD, "mul_neg");
        idle_check("mul_neg");
        run_op(EX_MULH_OP,   32'h8000_0000, 32'h8000_0000, "mulh");
        run_op(EX_MULHU_OP,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
        run_op(EX_MULHSU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        idle_check("mulhi");
    endtask

    task automatic test_div();
        run_op(EX_DIV_OP,  32'hFFFF_FFF9, 32'd2, "div_neg");
        run_op(EX_REM_OP,  32'hFFFF_FFF9, 32'd2, "rem_neg");
        run_op(EX_DIVU_OP, 32'd100, 32'd7, "divu");
        run_op(EX_REMU_OP, 32'd100, 32'd7, "remu");
        idle_check("div");
    endtask

    task automatic test_special();
        run_op(EX_DIV_OP,  32'd5, 32'd0, "div_by0");
        run_op(EX_REMU_OP, 32'd5, 32'd0, "remu_by0");
        run_op(EX_DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(EX_REM_OP,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        idle_check("special");
    endtask

    task automatic test_flush();
        bit bad;
        bad = 1'b0;
        @(posedge clk); #1;
        bus.ex_aluop   = EX_DIVU_OP;
        bus.ex_r1_data = 32'd1000;
        bus.ex_r2_data = 32'd3;
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.stallreq !== 1'b0 || bus.mdu_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_cycle: got stall=%b valid=%b expected 0 0", bus.stallreq, bus.mdu_valid);
        end
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.ex_aluop = EX_ADD_OP;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.stallreq !== 1'b0 || bus.mdu_valid !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL flush_after: got stall/valid activity expected none");
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus.ex_aluop   = EX_MUL_OP;
        bus.ex_r1_data = 32'd3;
        bus.ex_r2_data = 32'd5;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.flush    = 1'b1;
        bus.ex_aluop = EX_NOP_OP;
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.mdu_result !== 32'd0 || bus.mdu_valid !== 1'b0 || bus.stallreq !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: got result=%h valid=%b stall=%b expected 0 0 0",
                     bus.mdu_result, bus.mdu_valid, bus.stallreq);
        end
        run_op(EX_DIVU_OP, 32'd81, 32'd9, "after_rst");
        idle_check("after_rst");
    endtask

    task automatic test_back_to_back();
        run_op(EX_DIVU_OP, 32'd100, 32'd7, "b2b_divu");
        run_op(EX_MUL_OP, 32'hFFFF_FFFA, 32'd7, "b2b_mul");
        run_op(EX_DIV_OP, 32'd9, 32'd0, "b2b_div0");
        run_op(EX_REM_OP, 32'hFFFF_FF9C, 32'd7, "b2b_rem");
        idle_check("b2b");
    endtask

    task automatic test_random();
        alu_op_t ops[8];
        alu_op_t op;
        logic [31:0] a, b;
        ops = '{EX_MUL_OP, EX_MULH_OP, EX_MULHSU_OP, EX_MULHU_OP,
                EX_DIV_OP, EX_DIVU_OP, EX_REM_OP, EX_REMU_OP};
        for (int i = 0; i < 16; i++) begin
            op = ops[$urandom_range(0, 7)];
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            run_op(op, a, b, "random");
        end
        idle_check("random");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit inside the EX stage. It consumes the operation and operands registered by the ID/EX pipeline register. While an M-extension operation is in progress it raises a stall request to the pipeline controller, and it presents one registered 32-bit result when the operation completes. Non-M operations pass through untouched: the unit stays idle and never stalls.

## Interface

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- ex_aluop  in  `AluOpBus  operation from ID/EX; M ops are `EX_MUL_OP, `EX_MULH_OP, `EX_MULHSU_OP, `EX_MULHU_OP, `EX_DIV_OP, `EX_DIVU_OP, `EX_REM_OP, `EX_REMU_OP.
- ex_r1_data  in  XLEN  rs1 operand.
- ex_r2_data  in  XLEN  rs2 operand.
- flush  in  1  synchronous abort of any in-flight operation.
- mdu_result  out  XLEN  result; meaningful only while mdu_valid is high.
- mdu_valid  out  1  high for exactly one cycle, in DONE.
- stallreq  out  1  stall request to the controller, which freezes stages 0–3.

## Operation

- FSM states: IDLE, BUSY, DONE.
- start = IDLE & ex_aluop is an M op & !flush.
- IDLE -> BUSY on start (normal case):
  - latch |r1| and |r2| according to signedness (MULHSU: r1 signed, r2 unsigned; DIVU/REMU/MULHU: both unsigned);
  - latch the result sign and the op;
  - clear the 6-bit counter and the 2*XLEN accumulator.
- IDLE -> DONE directly on start for special cases; the result is computed and registered in the start cycle:
  - divisor 0: DIV/DIVU -> all ones; REM/REMU -> r1.
  - signed overflow (r1 = 0x80000000, r2 = 0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- BUSY performs one iteration per cycle:
  - multiply: shift-add of the unsigned magnitudes into the 2*XLEN product;
  - divide: restoring shift-subtract, producing quotient and remainder.
- BUSY -> DONE when the counter reaches XLEN-1. On that edge the result is selected and registered:
  - MUL: low word;
  - MULH/MULHSU/MULHU: high word;
  - sign correction by two's complement of the full 2*XLEN product or of the quotient;
  - remainder takes the dividend's sign.
- DONE -> IDLE unconditionally. DONE never restarts, even though ID/EX still holds the same M op in that cycle.
- stallreq = (start | BUSY) & !flush; it is low in DONE.
- flush in BUSY or DONE -> IDLE on the next edge; mdu_valid stays low; stallreq drops in the same cycle.
- rst in any state -> IDLE, counter 0, accumulator 0.

## Timing

- Reset values: mdu_result = `ZeroWord, mdu_valid = 0, stallreq = 0, state IDLE.
- Normal op: 1 start cycle + XLEN BUSY cycles + 1 DONE cycle = 34 cycles in EX; stallreq is high for 33 cycles.
- Special-case divide: 2 cycles in EX, 1 stall cycle.
- Back-to-back M ops: the next op starts in the IDLE cycle immediately after DONE, with no bubble beyond that.
- rst wins over flush; flush wins over start.

## Configuration

- MDU_FAST_MUL_EN defined:
  - the four multiply ops use a combinational XLEN×XLEN multiplier;
  - IDLE -> DONE on start, so 1 stall cycle;
  - divides are unchanged.
- MDU_FAST_MUL_EN undefined: multiplies use the iterative BUSY path (33 stall cycles); no hardware multiplier is inferred.

## Structure

- The M-op encodings (`EX_MUL_OP … `EX_REMU_OP) and the `AluOpBus/`RegBus widths live in the shared definitions header with the other EX op codes.
- The FSM state encodings are local to this module.
- Sub-module mdu_iter_core holds the accumulator, counter and single-step shift-add/shift-subtract datapath. ex_muldiv owns the FSM, the special cases, sign handling and the result register.

## Test plan

- MUL 7 × 0xFFFFFFFD, macro off -> stallreq high 33 cycles, then mdu_valid for one cycle with mdu_result 0xFFFFFFEB.
- Multiply-high results:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000;
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- Divide/remainder results:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF;
  - DIVU 100 / 7 -> 14; REMU -> 2.
- Special cases, each with stallreq high exactly 1 cycle:
  - DIV 5 / 0 -> 0xFFFFFFFF;
  - REMU 5 / 0 -> 5;
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000;
  - REM -> 0.
- Abort and reset mid-operation:
  - flush on the 10th BUSY cycle -> stallreq low in that cycle, IDLE next, no mdu_valid;
  - rst on the 5th BUSY cycle -> all outputs 0 next cycle.
- DIVU held on ex_aluop through DONE -> exactly one mdu_valid pulse, no restart. A following MUL starts the cycle after DONE. With MDU_FAST_MUL_EN, that MUL shows 1 stall cycle and a correct result.
